// File: rtl/uart_host_bridge.sv
// rtl/uart_host_bridge.sv - byte stream to memory-mapped uart register bridge with paced TX FIFO
module uart_host_bridge #(
    parameter int TX_DEPTH   = 16,
    parameter int TX_GAP     = 4340,
    parameter int RD_TIMEOUT = 15
) (
    input  logic                      clk_50m_i,
    input  logic                      rst_n_i,
    input  logic [7:0]                tx_data_i,
    input  logic                      tx_valid_i,
    output logic                      tx_ready_o,
    output logic [$clog2(TX_DEPTH):0] tx_level_o,
    output logic [7:0]                rx_data_o,
    output logic                      rx_valid_o,
    output logic                      rd_timeout_o,
    output logic [31:0]               addr_32b_o,
    output logic                      wren_o,
    output logic                      rden_o,
    output logic [31:0]               din_32b_o,
    input  logic [31:0]               dout_32b_i,
    input  logic                      dout_32b_valid_i,
    input  logic                      interrupt_i
);

    localparam int AW = $clog2(TX_DEPTH);
    localparam int LW = AW + 1;
    localparam int GW = (TX_GAP > 1) ? $clog2(TX_GAP) : 1;
    localparam int TW = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;

    localparam logic [GW-1:0] GAP_LOAD   = GW'(TX_GAP - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(RD_TIMEOUT - 1);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(TX_DEPTH);
    localparam logic [31:0]   ADDR_TX    = 32'h1001_0004;
    localparam logic [31:0]   ADDR_RX    = 32'h1001_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_WAIT_RD,
        S_HOLDOFF
    } state_t;

    state_t state, next_state;

    logic [7:0]    mem [TX_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level, level_next;
    logic          push, pop, fifo_empty;
    logic [GW-1:0] gap_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          hold_cnt;
    logic [23:0]   unused_dout_hi;

    assign unused_dout_hi = dout_32b_i[31:8];
    assign tx_level_o     = level;
    assign fifo_empty     = (level == '0);
    assign push           = tx_valid_i && tx_ready_o;
    // The FIFO head is consumed on the edge that enters WRITE, so din is captured from it there.
    assign pop            = (next_state == S_WRITE);

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (interrupt_i) begin
                    next_state = S_READ;
                end else if (!fifo_empty && gap_cnt == '0) begin
                    next_state = S_WRITE;
                end
            end
            S_WRITE:   next_state = S_IDLE;
            S_READ:    next_state = S_WAIT_RD;
            S_WAIT_RD: begin
                if (dout_32b_valid_i || tmo_cnt == TMO_LAST) begin
                    next_state = S_HOLDOFF;
                end
            end
            S_HOLDOFF: begin
                if (hold_cnt) begin
                    next_state = S_IDLE;
                end
            end
            default:   next_state = S_IDLE;
        endcase
    end

    always_comb begin
        level_next = level;
        case ({push, pop})
            2'b10:   level_next = level + LW'(1);
            2'b01:   level_next = level - LW'(1);
            default: level_next = level;
        endcase
    end

    always_ff @(posedge clk_50m_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk_50m_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            tx_ready_o <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level      <= level_next;
            tx_ready_o <= (level_next < LEVEL_FULL);
        end
    end

    always_ff @(posedge clk_50m_i) begin
        if (push) begin
            mem[wr_ptr] <= tx_data_i;
        end
    end

    // Gap pacing runs in every state so a read can overlap the inter-frame gap.
    always_ff @(posedge clk_50m_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            gap_cnt  <= '0;
            tmo_cnt  <= '0;
            hold_cnt <= 1'b0;
        end else begin
            if (next_state == S_WRITE) begin
                gap_cnt <= GAP_LOAD;
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GW'(1);
            end

            if (state == S_READ) begin
                tmo_cnt <= '0;
            end else if (state == S_WAIT_RD && tmo_cnt != TMO_LAST) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end

            hold_cnt <= (state == S_HOLDOFF) && !hold_cnt;
        end
    end

    always_ff @(posedge clk_50m_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wren_o       <= 1'b0;
            rden_o       <= 1'b0;
            addr_32b_o   <= '0;
            din_32b_o    <= '0;
            rx_data_o    <= '0;
            rx_valid_o   <= 1'b0;
            rd_timeout_o <= 1'b0;
        end else begin
            wren_o     <= (next_state == S_WRITE);
            rden_o     <= (next_state == S_READ);
            rx_valid_o <= (state == S_WAIT_RD) && dout_32b_valid_i;

            if (next_state == S_WRITE) begin
                addr_32b_o <= ADDR_TX;
                din_32b_o  <= {24'h0, mem[rd_ptr]};
            end else if (next_state == S_READ) begin
                addr_32b_o <= ADDR_RX;
            end

            if (state == S_WAIT_RD && dout_32b_valid_i) begin
                rx_data_o <= dout_32b_i[7:0];
            end
            if (state == S_WAIT_RD && !dout_32b_valid_i && tmo_cnt == TMO_LAST) begin
                rd_timeout_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_host_bridge.sv
// tb/tb_uart_host_bridge.sv - randomized bench for uart_host_bridge with queue-based reference model
module tb_uart_host_bridge;

    localparam int DEPTH  = 4;
    localparam int TX_GAP = 8;
    localparam int RD_TO  = 15;

    logic        clk;
    logic        rst_n;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [2:0]  tx_level;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rd_timeout;
    logic [31:0] addr;
    logic        wren;
    logic        rden;
    logic [31:0] din;
    logic [31:0] dout;
    logic        dout_valid;
    logic        interrupt;

    uart_host_bridge #(.TX_DEPTH(DEPTH), .TX_GAP(TX_GAP), .RD_TIMEOUT(RD_TO)) dut (
        .clk_50m_i        (clk),
        .rst_n_i          (rst_n),
        .tx_data_i        (tx_data),
        .tx_valid_i       (tx_valid),
        .tx_ready_o       (tx_ready),
        .tx_level_o       (tx_level),
        .rx_data_o        (rx_data),
        .rx_valid_o       (rx_valid),
        .rd_timeout_o     (rd_timeout),
        .addr_32b_o       (addr),
        .wren_o           (wren),
        .rden_o           (rden),
        .din_32b_o        (din),
        .dout_32b_i       (dout),
        .dout_32b_valid_i (dout_valid),
        .interrupt_i      (interrupt)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    bit         in_reset, loopback, rand_delay, noise, fixed_resp, exp_to;
    int         rd_delay, rd_wait, accepted, wr_cnt, rd_cnt, rx_cnt;
    int         wr_last, wr_prev, rd_last, rx_cyc, to_win;
    logic [7:0] resp_byte, last_rx;
    logic [7:0] tx_q[$], rx_q[$], lb_q[$], lb_rx[$];
    string      msg;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int model_level();
        return accepted - wr_cnt;
    endfunction

    function automatic bit busy();
        return tx_q.size() != 0 || rx_q.size() != 0 || lb_q.size() != 0 || rd_wait != 0 || interrupt;
    endfunction

    // One clock: advance, then observe the DUT against the model and play the uart side.
    task automatic tick();
        bit         accept, int_edge;
        logic [7:0] b;
        accept   = tx_valid && !in_reset && (model_level() < DEPTH);
        int_edge = interrupt;
        @(posedge clk);
        #1;
        cyc++;
        dout_valid = 1'b0;
        if (in_reset) begin
            check("rst_ready", 32'(tx_ready), 0);
            check("rst_level", 32'(tx_level), 0);
            check("rst_strobes", 32'({wren, rden, rx_valid, rd_timeout}), 0);
            check("rst_addr", addr, 0);
            check("rst_din_rx", din | 32'(rx_data), 0);
            return;
        end
        if (accept) begin
            tx_q.push_back(tx_data);
            accepted++;
        end
        check("strobe_excl", 32'(wren & rden), 0);
        if (wren) begin
            wr_cnt++;
            wr_prev = wr_last;
            wr_last = cyc;
            check("wr_pending", 32'(tx_q.size() != 0), 1);
            if (tx_q.size() != 0) begin
                b = tx_q.pop_front();
                check("wr_data", din, {24'h0, b});
            end
            check("wr_addr", addr, 32'h1001_0004);
            if (wr_prev >= 0) check("wr_gap_min", 32'((wr_last - wr_prev) >= TX_GAP), 1);
            if (loopback) begin
                lb_q.push_back(din[7:0]);
                interrupt = 1'b1;
            end
        end
        if (rden) begin
            rd_cnt++;
            rd_last = cyc;
            check("rd_cause", 32'(int_edge), 1);
            check("rd_addr", addr, 32'h1001_0000);
            interrupt = 1'b0;
            rd_wait = rand_delay ? int'($urandom_range(1, RD_TO)) : rd_delay;
            if (rd_wait == 0) to_win = cyc + RD_TO;
        end else if (rd_wait != 0) begin
            check("rd_addr_hold", addr, 32'h1001_0000);
            rd_wait--;
            if (rd_wait == 0) begin
                if (loopback) b = (lb_q.size() != 0) ? lb_q.pop_front() : 8'h00;
                else if (fixed_resp) b = resp_byte;
                else b = 8'($urandom);
                dout = $urandom;
                dout[7:0] = b;
                dout_valid = 1'b1;
                rx_q.push_back(b);
                if (loopback) interrupt = (lb_q.size() != 0);
            end
        end else if (noise && $urandom_range(0, 7) == 0) begin
            dout = $urandom;
            dout_valid = 1'b1;
        end
        if (rx_valid) begin
            rx_cnt++;
            rx_cyc  = cyc;
            last_rx = rx_data;
            check("rx_pending", 32'(rx_q.size() != 0), 1);
            if (rx_q.size() != 0) begin
                b = rx_q.pop_front();
                check("rx_data", 32'(rx_data), 32'(b));
            end
            if (loopback) lb_rx.push_back(rx_data);
        end
        if (to_win >= 0 && cyc == to_win + 2) exp_to = 1'b1;
        if (!(to_win >= 0 && (cyc == to_win || cyc == to_win + 1)))
            check("rd_timeout", 32'(rd_timeout), 32'(exp_to));
        check("tx_level", 32'(tx_level), model_level());
        check("tx_ready", 32'(tx_ready), 32'(model_level() < DEPTH));
    endtask

    task automatic do_reset();
        tx_valid = 1'b0;
        interrupt = 1'b0;
        dout_valid = 1'b0;
        rst_n = 1'b0;
        in_reset = 1'b1;
        tx_q.delete();
        rx_q.delete();
        lb_q.delete();
        accepted = 0;
        wr_cnt = 0;
        rd_wait = 0;
        exp_to = 1'b0;
        to_win = -100;
        wr_last = -1;
        wr_prev = -1;
        repeat (3) tick();
        rst_n = 1'b1;
        in_reset = 1'b0;
        tick();
    endtask

    task automatic wait_writes(input int n, input int budget);
        for (int i = 0; i < budget && wr_cnt < n; i++) tick();
        check("wait_writes", 32'(wr_cnt >= n), 1);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && busy(); i++) tick();
        check("drain", 32'(busy()), 0);
    endtask

    initial begin
        int base, idx;
        logic [7:0] b;
        rst_n = 1'b1;
        tx_data = 8'h00;
        tx_valid = 1'b0;
        dout = '0;
        dout_valid = 1'b0;
        interrupt = 1'b0;
        {loopback, rand_delay, noise, fixed_resp} = 4'b0;
        rd_delay = 2;
        rd_cnt = 0;
        rx_cnt = 0;
        rd_last = -1;
        rx_cyc = -1;
        msg = "Hello World!\n";
        #2;
        do_reset();
        repeat (5) tick();

        tx_valid = 1'b1; tx_data = 8'h48; tick();
        tx_data = 8'h65; tick();
        tx_valid = 1'b0;
        wait_writes(2, 40);
        check("gap_exact", wr_last - wr_prev, TX_GAP);
        repeat (TX_GAP + 2) tick();

        base = wr_cnt;
        tx_valid = 1'b1; tx_data = 8'hA0; tick();
        tx_valid = 1'b0;
        wait_writes(base + 1, 20);
        for (int i = 0; i <= DEPTH; i++) begin
            tx_valid = 1'b1;
            tx_data = 8'hB0 + 8'(i);
            tick();
        end
        tx_valid = 1'b0;
        check("full_level", 32'(tx_level), DEPTH);
        check("full_ready", 32'(tx_ready), 0);
        wait_drain(200);
        repeat (TX_GAP + 2) tick();

        base = rd_cnt;
        rd_delay = 2;
        tx_valid = 1'b1; tx_data = 8'hC3; tick();
        tx_valid = 1'b0;
        interrupt = 1'b1;
        idx = wr_cnt;
        wait_writes(idx + 1, 60);
        check("rd_before_wr", 32'(rd_cnt > base && rd_last < wr_last), 1);
        check("wr_after_hold", 32'(wr_last - rx_cyc >= 3), 1);
        wait_drain(100);

        rd_delay = 3; fixed_resp = 1'b1; resp_byte = 8'h6C;
        base = rx_cnt;
        interrupt = 1'b1;
        for (int i = 0; i < 40 && rx_cnt == base; i++) tick();
        check("rx_6c", 32'(last_rx), 32'h6C);
        check("rx_latency", rx_cyc - rd_last, 4);
        check("no_timeout", 32'(rd_timeout), 0);
        fixed_resp = 1'b0;
        wait_drain(50);

        rd_delay = 0;
        interrupt = 1'b1;
        repeat (RD_TO + 10) tick();
        check("timeout_set", 32'(rd_timeout), 1);
        base = wr_cnt;
        tx_valid = 1'b1; tx_data = 8'h5A; tick();
        tx_valid = 1'b0;
        wait_writes(base + 1, 40);

        rand_delay = 1'b1;
        noise = 1'b1;
        for (int i = 0; i < 600; i++) begin
            tx_valid = ($urandom_range(0, 1) == 1);
            tx_data = 8'($urandom);
            if (!interrupt && $urandom_range(0, 15) == 0) interrupt = 1'b1;
            tick();
        end
        tx_valid = 1'b0;
        noise = 1'b0;
        wait_drain(300);

        loopback = 1'b1;
        lb_rx.delete();
        idx = 0;
        for (int i = 0; i < 3000 && lb_rx.size() < 13; i++) begin
            if (idx < 13 && model_level() < DEPTH) begin
                tx_valid = 1'b1;
                tx_data = msg[idx];
                idx++;
            end else begin
                tx_valid = 1'b0;
            end
            tick();
        end
        tx_valid = 1'b0;
        wait_drain(200);
        loopback = 1'b0;
        check("loop_count", lb_rx.size(), 13);
        for (int i = 0; i < 13; i++) begin
            b = (i < lb_rx.size()) ? lb_rx[i] : 8'h00;
            check("loop_byte", 32'(b), 32'(msg[i]));
        end

        rand_delay = 1'b0;
        rd_delay = 6;
        repeat (TX_GAP + 2) tick();
        tx_valid = 1'b1; tx_data = 8'h11; tick();
        tx_data = 8'h22; tick();
        tx_data = 8'h33; tick();
        tx_valid = 1'b0;
        interrupt = 1'b1;
        tick();
        tick();
        do_reset();
        repeat (20) tick();
        check("abort_level", 32'(tx_level), 0);
        check("abort_writes", wr_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
